// File: rtl/sap_cg_pkg.sv
// sap_cg_pkg: shared state encoding and default parameters for the SAP clock-gate controller
package sap_cg_pkg;
  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_DRAIN = 2'd1,
    CG_GATED = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;
  localparam int CG_IDLE_WAIT_DEFAULT   = 4;
  localparam int CG_WAKE_SETTLE_DEFAULT = 2;
  localparam int CG_TIMEOUT_DEFAULT     = 255;
  localparam int CG_CNT_W_DEFAULT       = 8;
endpackage

// File: rtl/sap_clock_gate_ctrl.sv
// sap_clock_gate_ctrl: sleep handshake and idle-qualified clock-gate enable for one SAP domain
module sap_clock_gate_ctrl
  import sap_cg_pkg::*;
#(
  parameter int IDLE_WAIT_CYCLES   = CG_IDLE_WAIT_DEFAULT,
  parameter int WAKE_SETTLE_CYCLES = CG_WAKE_SETTLE_DEFAULT,
  parameter int TIMEOUT_CYCLES     = CG_TIMEOUT_DEFAULT,
  parameter int CNT_W              = CG_CNT_W_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       test_mode_i,
  input  logic       sleep_req_i,
  output logic       sleep_ack_o,
  input  logic       wake_req_i,
  input  logic       domain_idle_i,
  output logic       clk_en_o,
  output logic       busy_o,
  output logic       abort_o,
  output logic [1:0] state_o
);
  localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(WAKE_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  cg_state_e        state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             rearm_q, rearm_d;
  logic             abort_q, abort_d;
  logic             wake;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign wake = wake_req_i | !sleep_req_i | test_mode_i;

  // next-state, counter and rearm logic; wake beats idle-complete beats timeout
  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    settle_cnt_d = settle_cnt_q;
    rearm_d      = rearm_q;
    abort_d      = 1'b0;
    case (state_q)
      CG_RUN: begin
        if (!sleep_req_i) rearm_d = 1'b1;
        if (sleep_req_i && rearm_q && !wake_req_i && !test_mode_i) begin
          state_d    = CG_DRAIN;
          idle_cnt_d = '0;
          tmo_cnt_d  = '0;
        end
      end
      CG_DRAIN: begin
        tmo_cnt_d  = sat_inc(tmo_cnt_q);
        idle_cnt_d = domain_idle_i ? sat_inc(idle_cnt_q) : '0;
        if (wake) begin
          state_d = CG_RUN;
          if (sleep_req_i) rearm_d = 1'b0;
        end else if (domain_idle_i && idle_cnt_q == IDLE_LAST) begin
          state_d = CG_GATED;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = CG_RUN;
          abort_d = 1'b1;
          rearm_d = 1'b0;
        end
      end
      CG_GATED: begin
        if (wake) begin
          state_d      = CG_WAKE;
          settle_cnt_d = '0;
        end
      end
      CG_WAKE: begin
        settle_cnt_d = sat_inc(settle_cnt_q);
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = CG_RUN;
          if (sleep_req_i) rearm_d = 1'b0;
        end
      end
    endcase
  end

  // state and counter registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= CG_RUN;
      idle_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      settle_cnt_q <= '0;
      rearm_q      <= 1'b1;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      rearm_q      <= rearm_d;
      abort_q      <= abort_d;
    end
  end

  assign clk_en_o    = state_q != CG_GATED;
  assign sleep_ack_o = state_q == CG_GATED;
  assign busy_o      = state_q != CG_RUN;
  assign abort_o     = abort_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_sap_clock_gate_ctrl.sv
// tb_sap_clock_gate_ctrl: directed-vector bench for the SAP clock-gate controller
module tb_sap_clock_gate_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       test_mode_i = 1'b0;
  logic       sleep_req_i = 1'b0;
  logic       wake_req_i = 1'b0;
  logic       domain_idle_i = 1'b0;
  logic       sleep_ack_o, clk_en_o, busy_o, abort_o;
  logic [1:0] state_o;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] glitch_pat = 8'b1111_0111;

  sap_clock_gate_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i),
    .sleep_req_i(sleep_req_i), .sleep_ack_o(sleep_ack_o), .wake_req_i(wake_req_i),
    .domain_idle_i(domain_idle_i), .clk_en_o(clk_en_o), .busy_o(busy_o),
    .abort_o(abort_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    sleep_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_clk_en", clk_en_o, 1);
      chk("rst_ack", sleep_ack_o, 0);
      chk("rst_state", state_o, 0);
    end
    chk("rst_busy", busy_o, 0);
    chk("rst_abort", abort_o, 0);
    sleep_req_i = 1'b0;
    rst_ni = 1'b1;
    step();
    chk("idle_run", state_o, 0);

    sleep_req_i = 1'b1;
    step();
    chk("nom_drain", state_o, 1);
    chk("nom_busy", busy_o, 1);
    chk("nom_clk_en_drain", clk_en_o, 1);
    domain_idle_i = 1'b1;
    step(3);
    chk("nom_c4_drain", state_o, 1);
    step();
    chk("nom_gated", state_o, 2);
    chk("nom_clk_en", clk_en_o, 0);
    chk("nom_ack", sleep_ack_o, 1);
    step(5);
    chk("nom_hold", state_o, 2);

    sleep_req_i = 1'b0;
    step();
    chk("wake_state", state_o, 3);
    chk("wake_clk_en", clk_en_o, 1);
    chk("wake_ack", sleep_ack_o, 0);
    step();
    chk("wake_settle", state_o, 3);
    step();
    chk("wake_run", state_o, 0);
    chk("wake_busy", busy_o, 0);

    domain_idle_i = 1'b0;
    sleep_req_i = 1'b1;
    step();
    chk("glitch_drain", state_o, 1);
    for (int i = 0; i < 8; i++) begin
      domain_idle_i = glitch_pat[i];
      step();
      chk($sformatf("glitch_c%0d", i + 2), state_o, (i == 7) ? 2 : 1);
    end
    sleep_req_i = 1'b0;
    domain_idle_i = 1'b0;
    step(3);
    chk("glitch_back_run", state_o, 0);

    sleep_req_i = 1'b1;
    step();
    chk("tmo_drain", state_o, 1);
    step(254);
    chk("tmo_c255_drain", state_o, 1);
    chk("tmo_c255_abort", abort_o, 0);
    step();
    chk("tmo_run", state_o, 0);
    chk("tmo_abort", abort_o, 1);
    step();
    chk("tmo_abort_once", abort_o, 0);
    step(5);
    chk("tmo_no_rearm", state_o, 0);
    sleep_req_i = 1'b0;
    step();
    sleep_req_i = 1'b1;
    step();
    chk("tmo_rearmed", state_o, 1);
    sleep_req_i = 1'b0;
    step();
    chk("tmo_withdraw", state_o, 0);

    sleep_req_i = 1'b1;
    domain_idle_i = 1'b1;
    step();
    chk("cw_drain", state_o, 1);
    step(3);
    wake_req_i = 1'b1;
    step();
    chk("cw_run", state_o, 0);
    chk("cw_clk_en", clk_en_o, 1);
    wake_req_i = 1'b0;
    step(2);
    chk("cw_no_rearm", state_o, 0);
    sleep_req_i = 1'b0;
    step();

    sleep_req_i = 1'b1;
    step(5);
    chk("tm_gated", state_o, 2);
    test_mode_i = 1'b1;
    step();
    chk("tm_wake", state_o, 3);
    chk("tm_clk_en", clk_en_o, 1);
    step(2);
    chk("tm_run", state_o, 0);
    test_mode_i = 1'b0;
    sleep_req_i = 1'b0;
    step();
    test_mode_i = 1'b1;
    sleep_req_i = 1'b1;
    step(3);
    chk("tm_blocks_sleep", state_o, 0);
    chk("tm_blocks_clk_en", clk_en_o, 1);
    test_mode_i = 1'b0;
    step();
    chk("tm_release_drain", state_o, 1);

    rst_ni = 1'b0;
    step();
    chk("rst_mid_drain", state_o, 0);
    rst_ni = 1'b1;
    step(6);
    chk("rst_regate", state_o, 2);
    rst_ni = 1'b0;
    step();
    chk("rst_mid_gated", state_o, 0);
    chk("rst_mid_gated_clk_en", clk_en_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
